conv_layer_sequencer: RTL and testbench
=======================================

// Module: conv_layer_sequencer
// PURPOSE
//  Sequences top_level_conv across all output channels of one layer. Per output channel:
//  - resets the conv core and pulses its kernel-load strobe
//  - gates the 256-bit input stream from the DMA into the core, counts beats, generates s_axis_tlast
//  - waits for conv_DONE, then advances the output-channel / bias index
//  Sits between the AXI-GPIO control registers, the input DMA and top_level_conv.
// PARAMETERS
//  DATA_W         256  stream data width (pass-through)
//  OUT_CH_W       9    width of output-channel count (max 256 channels)
//  BEAT_W         21   beat counter width (max 64*64*256+256 = 1048832 beats)
//  RST_CYCLES     5    cycles conv_rst_n held low per channel
//  SETTLE_CYCLES  10   idle cycles after kernel-load pulse before streaming
//  WDOG_CYCLES    2^20 WAIT_DONE timeout, used only with CONV_SEQ_WDOG_EN
// PORTS
//  clk                 in   1        clock
//  aresetn             in   1        synchronous active-low reset
//  start               in   1        1-cycle pulse, accepted only in IDLE
//  num_out_ch          in   OUT_CH_W output channels to run (0 = illegal)
//  channel_size_choose in   2        0:256 1:128 2:64 3:32 input channels
//  image_size_choose   in   3        0:4 1:8 2:16 3:32 4:64 (5-7 illegal)
//  up_tdata            in   DATA_W   DMA stream data
//  up_tvalid           in   1        DMA stream valid
//  up_tready           out  1        DMA stream ready
//  conv_tdata          out  DATA_W   = up_tdata (combinational)
//  conv_tvalid         out  1        to core s_axis_tvalid
//  conv_tready         in   1        from core s_axis_tready
//  conv_tlast          out  1        to core s_axis_tlast
//  conv_rst_n          out  1        to core Reset_top (active low)
//  conv_load_kernel    out  1        to core Load_kernel_BRAM
//  conv_channel_choose out  2        registered copy of channel_size_choose
//  conv_image_choose   out  3        registered copy of image_size_choose
//  conv_done           in   1        from core conv_DONE (level or pulse)
//  out_ch_idx          out  OUT_CH_W current output channel = bias BRAM base
//  busy                out  1        high in every state except IDLE
//  layer_done          out  1        1-cycle pulse after last channel completes
//  cfg_err             out  1        sticky; set on illegal config at start
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 except conv_rst_n=0; counters and cfg_err cleared.
//  - Reset mid-operation aborts immediately; no tlast emitted; next start begins at channel 0.
//  - start in IDLE with legal config latches config and num_out_ch, out_ch_idx=0, -> RST.
//  - start in IDLE with illegal config (image 5-7 or num_out_ch=0): cfg_err=1, stay IDLE.
//  - start outside IDLE is ignored. cfg_err clears only on the next legal start.
//  - FSM states:
//    - IDLE
//    - RST: conv_rst_n=0 for RST_CYCLES, then -> LOAD
//    - LOAD: conv_load_kernel=1 for exactly 1 cycle -> SETTLE
//    - SETTLE: wait SETTLE_CYCLES -> STREAM
//    - STREAM: described below
//    - WAIT_DONE: wait for conv_done=1; then out_ch_idx==num_out_ch-1 -> FIN, else idx++ -> RST
//    - FIN: layer_done=1 for one cycle -> IDLE
//  - STREAM:
//    - conv_tvalid = up_tvalid; up_tready = conv_tready; both forced 0 in all other states.
//    - Beat accepted when conv_tvalid & conv_tready; beat counter increments only then.
//    - Total beats N = C + S*S*C (kernel first, then image), C/S decoded from the latched config.
//    - conv_tlast=1 exactly while beat count == N-1; holds if stalled; 0 elsewhere.
//    - On acceptance of beat N-1 -> WAIT_DONE next cycle.
//  - up_tdata/up_tvalid changes while up_tready=0 pass through unaltered; no buffering, zero latency.
//  - A conv_done arriving during STREAM is ignored; only WAIT_DONE samples it.
//  - conv_done already high on WAIT_DONE entry completes in that cycle.
// CONFIGURATION
//  - CONV_SEQ_WDOG_EN defined: cycle counter runs in WAIT_DONE.
//    On reaching WDOG_CYCLES: sets sticky cfg_err, pulses layer_done, returns to IDLE.
//  - CONV_SEQ_WDOG_EN undefined: no counter; WAIT_DONE waits indefinitely.
// TESTING
//  1. image=0 (4x4), channel=0 (256), num_out_ch=1, tready always 1
//     -> 4352 beats; tlast only on beat 4352; conv_done -> one layer_done pulse.
//  2. Same config, conv_tready toggled 1-of-3 cycles
//     -> still exactly 4352 transfers; tlast held while stalled on the last beat; no dropped beats.
//  3. num_out_ch=3
//     -> three RST(5)/LOAD(1)/SETTLE(10) sequences; out_ch_idx 0,1,2; one layer_done at end.
//  4. image=5 or num_out_ch=0
//     -> cfg_err=1, busy stays 0; a following legal start clears cfg_err and runs.
//  5. aresetn low during STREAM at beat 100
//     -> outputs return to reset values next cycle; a new start streams the full 4352 beats.
//  6. CONV_SEQ_WDOG_EN with WDOG_CYCLES=64, conv_done never asserted
//     -> cfg_err=1 and layer_done after 64 WAIT_DONE cycles.

Source files
------------

// File: rtl/conv_layer_sequencer.sv
// Per-output-channel sequencer for top_level_conv: core reset, kernel load, gated input stream, done wait.
// Optional WAIT_DONE watchdog is built in when CONV_SEQ_WDOG_EN is defined.
module conv_layer_sequencer #(
    parameter int DATA_W        = 256,
    parameter int OUT_CH_W      = 9,
    parameter int BEAT_W        = 21,
    parameter int RST_CYCLES    = 5,
    parameter int SETTLE_CYCLES = 10,
    parameter int WDOG_CYCLES   = 2**20
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                start,
    input  logic [OUT_CH_W-1:0] num_out_ch,
    input  logic [1:0]          channel_size_choose,
    input  logic [2:0]          image_size_choose,
    input  logic [DATA_W-1:0]   up_tdata,
    input  logic                up_tvalid,
    output logic                up_tready,
    output logic [DATA_W-1:0]   conv_tdata,
    output logic                conv_tvalid,
    input  logic                conv_tready,
    output logic                conv_tlast,
    output logic                conv_rst_n,
    output logic                conv_load_kernel,
    output logic [1:0]          conv_channel_choose,
    output logic [2:0]          conv_image_choose,
    input  logic                conv_done,
    output logic [OUT_CH_W-1:0] out_ch_idx,
    output logic                busy,
    output logic                layer_done,
    output logic                cfg_err
);

    // state  | meaning
    // IDLE   | waiting for start, core held in reset
    // RST    | core reset asserted for RST_CYCLES
    // LOAD   | one-cycle kernel-load strobe
    // SETTLE | SETTLE_CYCLES idle before streaming
    // STREAM | kernel + image beats gated into the core
    // WAIT   | waiting for conv_done
    // FIN    | one-cycle layer_done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_LOAD, S_SETTLE, S_STREAM, S_WAIT, S_FIN
    } state_t;

    localparam int TMR_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
`ifdef CONV_SEQ_WDOG_EN
    localparam int CNT_MAX = (WDOG_CYCLES > TMR_MAX) ? WDOG_CYCLES : TMR_MAX;
`else
    localparam int CNT_MAX = TMR_MAX;
`endif
    localparam int CNT_W = $clog2(CNT_MAX) + 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BEAT_W-1:0]   last_q, last_d;
    logic [OUT_CH_W-1:0] idx_q, idx_d;
    logic [OUT_CH_W-1:0] num_q, num_d;
    logic [1:0]          chan_q, chan_d;
    logic [2:0]          img_q, img_d;
    logic                err_q, err_d;

    logic                cfg_ok;
    logic [BEAT_W-1:0]   c_beats;
    logic [BEAT_W-1:0]   last_beat;
    logic [4:0]          img_sh;

    // N - 1 = C + C*S*S - 1, with S*S = 16 << (2*image_size_choose)
    always_comb begin
        c_beats   = BEAT_W'(256) >> channel_size_choose;
        img_sh    = 5'd4 + {1'b0, image_size_choose, 1'b0};
        last_beat = c_beats + (c_beats << img_sh) - BEAT_W'(1);
        cfg_ok    = (image_size_choose <= 3'd4) && (num_out_ch != '0);
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        beat_d           = beat_q;
        last_d           = last_q;
        idx_d            = idx_q;
        num_d            = num_q;
        chan_d           = chan_q;
        img_d            = img_q;
        err_d            = err_q;
        conv_rst_n       = 1'b1;
        conv_load_kernel = 1'b0;
        conv_tvalid      = 1'b0;
        up_tready        = 1'b0;
        conv_tlast       = 1'b0;
        layer_done       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                conv_rst_n = 1'b0;
                if (start) begin
                    if (cfg_ok) begin
                        err_d   = 1'b0;
                        num_d   = num_out_ch;
                        chan_d  = channel_size_choose;
                        img_d   = image_size_choose;
                        last_d  = last_beat;
                        idx_d   = '0;
                        cnt_d   = CNT_W'(RST_CYCLES - 1);
                        state_d = S_RST;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RST: begin
                conv_rst_n = 1'b0;
                if (cnt_q == '0) state_d = S_LOAD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_LOAD: begin
                conv_load_kernel = 1'b1;
                cnt_d            = CNT_W'(SETTLE_CYCLES - 1);
                state_d          = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    beat_d  = '0;
                    state_d = S_STREAM;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STREAM: begin
                conv_tvalid = up_tvalid;
                up_tready   = conv_tready;
                conv_tlast  = (beat_q == last_q);
                if (up_tvalid && conv_tready) begin
                    if (beat_q == last_q) begin
                        state_d = S_WAIT;
`ifdef CONV_SEQ_WDOG_EN
                        cnt_d   = CNT_W'(WDOG_CYCLES - 1);
`endif
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (conv_done) begin
                    if (idx_q == num_q - OUT_CH_W'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q + OUT_CH_W'(1);
                        cnt_d   = CNT_W'(RST_CYCLES - 1);
                        state_d = S_RST;
                    end
                end
`ifdef CONV_SEQ_WDOG_EN
                else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            S_FIN: begin
                layer_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            last_q  <= '0;
            idx_q   <= '0;
            num_q   <= '0;
            chan_q  <= '0;
            img_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            chan_q  <= chan_d;
            img_q   <= img_d;
            err_q   <= err_d;
        end
    end

    assign conv_tdata          = up_tdata;
    assign conv_channel_choose = chan_q;
    assign conv_image_choose   = img_q;
    assign out_ch_idx          = idx_q;
    assign busy                = (state_q != S_IDLE);
    assign cfg_err             = err_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench for conv_layer_sequencer: randomized handshakes against a phase/beat-count model.
// Define CONV_SEQ_WDOG_EN to also exercise the WAIT_DONE watchdog with WDOG_CYCLES=64.
module tb_conv_layer_sequencer;

    localparam int OUT_CH_W = 9;
    localparam int RST_N    = 5;
    localparam int SETTLE_N = 10;
    localparam int WDOG     = 64;

    logic                clk = 1'b0;
    logic                aresetn;
    logic                start;
    logic [OUT_CH_W-1:0] num_out_ch;
    logic [1:0]          channel_size_choose;
    logic [2:0]          image_size_choose;
    logic [255:0]        up_tdata;
    logic                up_tvalid;
    logic                up_tready;
    logic [255:0]        conv_tdata;
    logic                conv_tvalid;
    logic                conv_tready;
    logic                conv_tlast;
    logic                conv_rst_n;
    logic                conv_load_kernel;
    logic [1:0]          conv_channel_choose;
    logic [2:0]          conv_image_choose;
    logic                conv_done;
    logic [OUT_CH_W-1:0] out_ch_idx;
    logic                busy;
    logic                layer_done;
    logic                cfg_err;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    always #5 clk = ~clk;

    conv_layer_sequencer #(.WDOG_CYCLES(WDOG)) dut (
        .clk                 (clk),
        .aresetn             (aresetn),
        .start               (start),
        .num_out_ch          (num_out_ch),
        .channel_size_choose (channel_size_choose),
        .image_size_choose   (image_size_choose),
        .up_tdata            (up_tdata),
        .up_tvalid           (up_tvalid),
        .up_tready           (up_tready),
        .conv_tdata          (conv_tdata),
        .conv_tvalid         (conv_tvalid),
        .conv_tready         (conv_tready),
        .conv_tlast          (conv_tlast),
        .conv_rst_n          (conv_rst_n),
        .conv_load_kernel    (conv_load_kernel),
        .conv_channel_choose (conv_channel_choose),
        .conv_image_choose   (conv_image_choose),
        .conv_done           (conv_done),
        .out_ch_idx          (out_ch_idx),
        .busy                (busy),
        .layer_done          (layer_done),
        .cfg_err             (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // e_idx < 0 skips the channel-index comparison
    task automatic chk_out(input string ph, input bit e_rstn, input bit e_load, input bit e_strm,
                           input bit e_tlast, input bit e_ldone, input bit e_busy, input bit e_err,
                           input int e_idx);
        chk({ph, ".rst_n"},  32'(conv_rst_n),       32'(e_rstn));
        chk({ph, ".load"},   32'(conv_load_kernel), 32'(e_load));
        chk({ph, ".tvalid"}, 32'(conv_tvalid),      32'(e_strm & up_tvalid));
        chk({ph, ".tready"}, 32'(up_tready),        32'(e_strm & conv_tready));
        chk({ph, ".tlast"},  32'(conv_tlast),       32'(e_tlast));
        chk({ph, ".ldone"},  32'(layer_done),       32'(e_ldone));
        chk({ph, ".busy"},   32'(busy),             32'(e_busy));
        chk({ph, ".cfgerr"}, 32'(cfg_err),          32'(e_err));
        if (e_idx >= 0) chk({ph, ".idx"}, 32'(out_ch_idx), 32'(e_idx));
        total++;
        assert (conv_tdata === up_tdata) else begin
            bad++;
            $error("FAIL %s.tdata observed=%h expected=%h", ph, conv_tdata, up_tdata);
        end
    endtask

    // mode 0: always valid/ready; 1: ready one cycle in three; 2: random both
    task automatic drive(input int mode);
        @(negedge clk);
        cyc_n++;
        start     = 1'b0;
        conv_done = 1'b0;
        for (int i = 0; i < 8; i++) up_tdata[i*32 +: 32] = $urandom();
        case (mode)
            0: begin up_tvalid = 1'b1; conv_tready = 1'b1; end
            1: begin up_tvalid = 1'b1; conv_tready = (cyc_n % 3 == 0); end
            default: begin
                up_tvalid   = ($urandom_range(0, 3) != 0);
                conv_tready = ($urandom_range(0, 3) != 0);
            end
        endcase
        #1;
    endtask

    task automatic run_layer(input int ch, input int img, input int nch, input int mode,
                             input int abort_at, input bit no_done);
        int c, s, n, beats, budget, w;
        c = 256 >> ch;
        s = 4 << img;
        n = c + s * s * c;
        drive(mode);
        start               = 1'b1;
        num_out_ch          = OUT_CH_W'(nch);
        channel_size_choose = 2'(ch);
        image_size_choose   = 3'(img);
        chk("start.busy", 32'(busy), 32'd0);
        for (int k = 0; k < nch; k++) begin
            for (int i = 0; i < RST_N; i++) begin
                drive(mode);
                chk_out("rst", 0, 0, 0, 0, 0, 1, 0, k);
                if (k == 0 && i == 0) begin
                    chk("rst.chan_sel", 32'(conv_channel_choose), 32'(ch));
                    chk("rst.img_sel",  32'(conv_image_choose),   32'(img));
                end
            end
            drive(mode);
            chk_out("load", 1, 1, 0, 0, 0, 1, 0, k);
            for (int i = 0; i < SETTLE_N; i++) begin
                drive(mode);
                chk_out("settle", 1, 0, 0, 0, 0, 1, 0, k);
            end
            beats  = 0;
            budget = 0;
            while (beats < n) begin
                drive(mode);
                conv_done = ($urandom_range(0, 7) == 0);
                if (beats == abort_at) begin
                    aresetn = 1'b0;
                    @(negedge clk);
                    aresetn   = 1'b1;
                    up_tvalid = 1'b1;
                    conv_tready = 1'b1;
                    conv_done = 1'b0;
                    #1;
                    chk_out("abort", 0, 0, 0, 0, 0, 0, 0, 0);
                    chk("abort.chan_sel", 32'(conv_channel_choose), 32'd0);
                    chk("abort.img_sel",  32'(conv_image_choose),   32'd0);
                    return;
                end
                if (k == 0 && beats == 5) start = 1'b1;
                chk_out("strm", 1, 0, 1, (beats == n - 1), 0, 1, 0, k);
                if (up_tvalid && conv_tready) beats++;
                budget++;
                if (budget > 4 * n + 64) begin
                    chk("strm.timeout_beats", 32'(beats), 32'(n));
                    return;
                end
            end
`ifdef CONV_SEQ_WDOG_EN
            if (no_done) begin
                for (int i = 0; i < WDOG; i++) begin
                    drive(0);
                    chk_out("wdog", 1, 0, 0, 0, 0, 1, 0, k);
                end
                drive(0);
                chk_out("wdog_fin", 1, 0, 0, 0, 1, 1, 1, k);
                drive(0);
                chk_out("wdog_idle", 0, 0, 0, 0, 0, 0, 1, -1);
                return;
            end
`endif
            w = $urandom_range(0, 3);
            for (int i = 0; i < w; i++) begin
                drive(0);
                chk_out("wait", 1, 0, 0, 0, 0, 1, 0, k);
            end
            drive(0);
            conv_done = 1'b1;
            chk_out("wait_done", 1, 0, 0, 0, 0, 1, 0, k);
        end
        drive(mode);
        chk_out("fin", 1, 0, 0, 0, 1, 1, 0, nch - 1);
        drive(mode);
        chk_out("idle", 0, 0, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic bad_start(input int img, input int nch);
        drive(0);
        start               = 1'b1;
        num_out_ch          = OUT_CH_W'(nch);
        channel_size_choose = 2'd0;
        image_size_choose   = 3'(img);
        for (int i = 0; i < 3; i++) begin
            drive(0);
            chk_out("badcfg", 0, 0, 0, 0, 0, 0, 1, -1);
        end
    endtask

    initial begin
        aresetn             = 1'b0;
        start               = 1'b0;
        num_out_ch          = '0;
        channel_size_choose = '0;
        image_size_choose   = '0;
        up_tdata            = '0;
        up_tvalid           = 1'b0;
        conv_tready         = 1'b0;
        conv_done           = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.chan_sel", 32'(conv_channel_choose), 32'd0);
        chk("reset.img_sel",  32'(conv_image_choose),   32'd0);
        aresetn = 1'b1;

        run_layer(0, 0, 1, 0, -1, 1'b0);
        run_layer(0, 0, 1, 1, -1, 1'b0);
        run_layer(3, 0, 3, 2, -1, 1'b0);

        bad_start(5, 1);
        bad_start(7, 2);
        bad_start(0, 0);
        run_layer(3, 1, 2, 2, -1, 1'b0);

        run_layer(0, 0, 1, 0, 100, 1'b0);
        run_layer(0, 0, 1, 0, -1, 1'b0);

        run_layer(3, 2, 1, 0, -1, 1'b0);
        for (int r = 0; r < 3; r++)
            run_layer($urandom_range(1, 3), 0, $urandom_range(1, 2), 2, -1, 1'b0);

`ifdef CONV_SEQ_WDOG_EN
        run_layer(3, 0, 1, 0, -1, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
